gen_reg_file: RTL and testbench

Parametrised general-purpose register file for the CPU datapath: `DEPTH` registers of `WIDTH` bits, two asynchronous read ports and one synchronous write port. It generalises the single enable/clear register into an addressable bank with an optional hardwired-zero R0. It also has a multi-cycle sweep-clear sequencer that zeroes the bank one register per cycle. It sits between the instruction decoder (register addresses) and the ALU operand/result buses.

---
 rtl/gen_reg_file.sv | 107 ++++++++++
 tb/tb_gen_reg_file.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gen_reg_file.sv
// Addressable register bank: two async read ports, one sync write port, optional hardwired-zero R0
// and a one-register-per-cycle sweep-clear sequencer. Optional macro: GEN_REG_FILE_BYPASS_EN.
module gen_reg_file #(
    parameter int              WIDTH   = 32,
    parameter int              DEPTH   = 16,
    parameter int              ZERO_R0 = 1,
    parameter logic [WIDTH-1:0] INIT   = '0,
    localparam int             AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             sweep_req,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic             wr_commit;
    logic [AW-1:0]    rd_addr [2];
    logic [WIDTH-1:0] rd_data [2];

    assign wr_ack    = wr_en & ~busy_q;
    assign busy      = busy_q;
    // A write to a hardwired R0 is still acknowledged; only the storage update is dropped.
    assign wr_commit = wr_ack & ~((ZERO_R0 != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sweep_req) begin
                        state_q <= SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sweep and write never collide: writes are only acked while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= ((ZERO_R0 != 0) && (i == 0)) ? '0 : INIT;
            end
        end else if (state_q == SWEEP) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_commit) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            if ((ZERO_R0 != 0) && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
            end
`ifdef GEN_REG_FILE_BYPASS_EN
            else if (wr_ack && (wr_addr == rd_addr[p])) begin
                rd_data[p] = wr_data;
            end
`endif
        end
    end

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];

endmodule

// File: tb/tb_gen_reg_file.sv
// Directed bench for gen_reg_file: reset, write/read, R0 hardwiring, bypass, sweep, reset abort.
module tb_gen_reg_file;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] INIT  = 32'hA5A5_0000;

    logic             clk = 1'b0;
    logic             clr;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ack;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             sweep_req;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cycles;

    gen_reg_file #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ZERO_R0(1),
        .INIT   (INIT)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .sweep_req(sweep_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic read_a(input logic [AW-1:0] a, input string tag, input logic [31:0] exp);
        rd_addr_a = a;
        #1;
        chk(tag, rd_data_a, exp);
    endtask

    initial begin
        clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; sweep_req = 1'b0;
        tick();
        clr = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        read_a(4'd0, "rst_r0", 32'd0);
        read_a(4'd1, "rst_r1", INIT);
        read_a(4'd15, "rst_r15", INIT);

        // Basic write then dual-port read of the same register.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h1234_5678;
        #1;
        chk("wr3_ack", {31'd0, wr_ack}, 32'd1);
        tick();
        wr_en = 1'b0; rd_addr_a = 4'd3; rd_addr_b = 4'd3;
        #1;
        chk("r3_a", rd_data_a, 32'h1234_5678);
        chk("r3_b", rd_data_b, 32'h1234_5678);

        // R0 write is acknowledged but discarded.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF_FFFF;
        #1;
        chk("wr0_ack", {31'd0, wr_ack}, 32'd1);
        tick();
        wr_en = 1'b0;
        read_a(4'd0, "r0_zero", 32'd0);

        // Same-cycle read of the register being written.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF; rd_addr_a = 4'd5;
        #1;
`ifdef GEN_REG_FILE_BYPASS_EN
        chk("r5_same_cycle", rd_data_a, 32'hDEAD_BEEF);
`else
        chk("r5_same_cycle", rd_data_a, INIT);
`endif
        tick();
        wr_en = 1'b0;
        read_a(4'd5, "r5_after", 32'hDEAD_BEEF);

        // Fill every register with a distinct pattern.
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'h1000_0000 + i;
            tick();
        end
        wr_en = 1'b0;
        read_a(4'd9, "fill_r9", 32'h1000_0009);

        // Sweep: busy rises on the sampling edge and lasts DEPTH cycles.
        sweep_req = 1'b1;
        tick();
        sweep_req = 1'b0;
        busy_cycles = 0;
        if (busy) busy_cycles++;
        for (int k = 1; k <= DEPTH; k++) begin
            if (k == 6) begin
                wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_0077;
                #1;
                chk("sweep_wr7_ack", {31'd0, wr_ack}, 32'd0);
            end
            tick();
            wr_en = 1'b0;
            if (busy) busy_cycles++;
            if (k == 4) begin
                read_a(4'd3, "sweep4_r3", 32'd0);
                read_a(4'd4, "sweep4_r4", 32'h1000_0004);
            end
            if (k == 6) read_a(4'd7, "sweep6_r7_kept", 32'h1000_0007);
        end
        chk("busy_cycles", busy_cycles, DEPTH);
        chk("sweep_done_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < DEPTH / 2; i++) begin
            rd_addr_a = AW'(i); rd_addr_b = AW'(i + DEPTH / 2);
            #1;
            chk($sformatf("swept_a%0d", i), rd_data_a, 32'd0);
            chk($sformatf("swept_b%0d", i + DEPTH / 2), rd_data_b, 32'd0);
        end

        // First write is accepted on the edge right after busy drops.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_0077;
        #1;
        chk("post_sweep_ack", {31'd0, wr_ack}, 32'd1);
        tick();
        wr_en = 1'b0;
        read_a(4'd7, "post_sweep_r7", 32'h0000_0077);

        // Reset in the middle of a sweep aborts it and reloads INIT.
        sweep_req = 1'b1;
        tick();
        sweep_req = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        clr = 1'b0;
        tick();
        clr = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        read_a(4'd0, "abort_r0", 32'd0);
        read_a(4'd1, "abort_r1", INIT);
        read_a(4'd7, "abort_r7", INIT);
        read_a(4'd15, "abort_r15", INIT);
        sweep_req = 1'b1;
        tick();
        sweep_req = 1'b0;
        chk("restart_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 40 && busy; k++) tick();
        chk("restart_drain", {31'd0, busy}, 32'd0);

        // Same-edge write and sweep request: write lands, then the sweep clears it.
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h0000_0055; sweep_req = 1'b1;
        tick();
        wr_en = 1'b0; sweep_req = 1'b0;
        chk("same_edge_busy", {31'd0, busy}, 32'd1);
        read_a(4'd2, "same_edge_r2_e0", 32'h0000_0055);
        tick();
        read_a(4'd2, "same_edge_r2_e1", 32'h0000_0055);
        tick();
        tick();
        read_a(4'd2, "same_edge_r2_e3", 32'd0);
        for (int k = 0; k < 40 && busy; k++) tick();
        chk("final_drain", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
